// File: rtl/cache_write_buffer.sv
// cache_write_buffer
//   Write-through store buffer between the L1 cache write path and the RAM/L2 port.
//   Stores are queued in a circular FIFO and drained to RAM one at a time with a
//   req/ack handshake. A store to the newest entry's address is merged into that
//   entry unless the entry is already on the RAM bus.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   wr_req_i/addr/data     store push from the cache
//   full_o, empty_o        registered occupancy flags
//   ram_write_start_o      registered, buffer holds at least one store
//   ram_req_o/addr/data    registered RAM write request, held until ram_ack_i
//   ram_ack_i              RAM accepted the current request
//   read_i, rd_addr_i      cache read probe
//   raw_hazard_o           combinational, read address matches a pending store
module cache_write_buffer #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_req_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              full_o,
   output logic              empty_o,
   output logic              ram_write_start_o,
   output logic              ram_req_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_data_o,
   input  logic              ram_ack_i,
   input  logic              read_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic              raw_hazard_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_mem_q [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];
   logic [PtrW-1:0]   head_q, tail_q, newest_idx;
   logic [CntW-1:0]   count_q, count_d;
   logic              coalesce, push, pop, latch;
   logic              ram_req_d;
   logic [ADDR_W-1:0] ram_addr_d;
   logic [DATA_W-1:0] ram_data_d;
   logic              entry_valid [DEPTH];

   // Push / coalesce / pop decode
   always_comb begin
      newest_idx = tail_q - PtrW'(1);
      // The newest entry is on the RAM bus only when it is also the head in ISSUE.
      coalesce   = wr_req_i && (count_q != '0) && (addr_mem_q[newest_idx] == wr_addr_i)
                   && !((state_q == StIssue) && (newest_idx == head_q));
      push       = wr_req_i && !coalesce && !full_o;
      pop        = (state_q == StIssue) && ram_ack_i;
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // Drain FSM
   always_comb begin
      state_d    = state_q;
      ram_req_d  = ram_req_o;
      ram_addr_d = ram_addr_o;
      ram_data_d = ram_data_o;
      latch      = 1'b0;
      case (state_q)
         StIdle:  if (count_q != '0) latch = 1'b1;
         StIssue: begin
            if (ram_ack_i) begin
               state_d   = StGap;
               ram_req_d = 1'b0;
            end
         end
         StGap: begin
            if (count_q != '0) latch = 1'b1;
            else               state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (latch) begin
         state_d    = StIssue;
         ram_req_d  = 1'b1;
         ram_addr_d = addr_mem_q[head_q];
         // A merge into the head on the latch edge must reach the bus, not the stale data.
         ram_data_d = (coalesce && (newest_idx == head_q)) ? wr_data_i : data_mem_q[head_q];
      end
   end

   // Read-after-write hazard against every occupied slot
   always_comb begin
      raw_hazard_o = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         entry_valid[i] = ({1'b0, PtrW'(i) - head_q} < count_q);
         if (read_i && entry_valid[i] && (addr_mem_q[i] == rd_addr_i)) raw_hazard_o = 1'b1;
      end
   end

   // Storage array; contents are don't-care outside the valid window
   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_mem_q[tail_q] <= wr_addr_i;
         data_mem_q[tail_q] <= wr_data_i;
      end else if (coalesce) begin
         data_mem_q[newest_idx] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q           <= StIdle;
         head_q            <= '0;
         tail_q            <= '0;
         count_q           <= '0;
         full_o            <= 1'b0;
         empty_o           <= 1'b1;
         ram_write_start_o <= 1'b0;
         ram_req_o         <= 1'b0;
         ram_addr_o        <= '0;
         ram_data_o        <= '0;
      end else begin
         state_q           <= state_d;
         count_q           <= count_d;
         full_o            <= (count_d == CntFull);
         empty_o           <= (count_d == '0);
         ram_write_start_o <= (count_d != '0);
         ram_req_o         <= ram_req_d;
         ram_addr_o        <= ram_addr_d;
         ram_data_o        <= ram_data_d;
         if (push) tail_q <= tail_q + PtrW'(1);
         if (pop)  head_q <= head_q + PtrW'(1);
      end
   end

endmodule

// File: tb/tb_cache_write_buffer.sv
// tb_cache_write_buffer
//   Directed bench for cache_write_buffer. Expected RAM writes are queued as
//   stores are issued; a negedge monitor pops and compares on every accepted
//   request (ram_req_o && ram_ack_i). Flags and the hazard output are checked
//   inline by the stimulus thread.
module tb_cache_write_buffer;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        wr_req_i = 1'b0;
   logic [31:0] wr_addr_i = '0;
   logic [31:0] wr_data_i = '0;
   logic        full_o, empty_o, ram_write_start_o, ram_req_o;
   logic [31:0] ram_addr_o, ram_data_o;
   logic        ram_ack_i = 1'b0;
   logic        read_i = 1'b0;
   logic [31:0] rd_addr_i = '0;
   logic        raw_hazard_o;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t sb[$];
   int  n_cmp = 0;
   int  n_fail = 0;

   always #5 clk = ~clk;

   cache_write_buffer #(
      .ADDR_W(32),
      .DATA_W(32),
      .DEPTH (4)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .wr_req_i         (wr_req_i),
      .wr_addr_i        (wr_addr_i),
      .wr_data_i        (wr_data_i),
      .full_o           (full_o),
      .empty_o          (empty_o),
      .ram_write_start_o(ram_write_start_o),
      .ram_req_o        (ram_req_o),
      .ram_addr_o       (ram_addr_o),
      .ram_data_o       (ram_data_o),
      .ram_ack_i        (ram_ack_i),
      .read_i           (read_i),
      .rd_addr_i        (rd_addr_i),
      .raw_hazard_o     (raw_hazard_o)
   );

   // Monitor: every accepted RAM write must match the oldest expected store
   always @(negedge clk) begin
      if (!rst_i && ram_req_o && ram_ack_i) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL ram_write: got %h/%h, expected no write", ram_addr_o, ram_data_o);
         end else begin
            wr_t e;
            e = sb.pop_front();
            if (ram_addr_o !== e.a || ram_data_o !== e.d) begin
               n_fail++;
               $display("FAIL ram_write: got %h/%h, expected %h/%h",
                        ram_addr_o, ram_data_o, e.a, e.d);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      wr_req_i  = 1'b1;
      wr_addr_i = a;
      wr_data_i = d;
      tick();
      wr_req_i  = 1'b0;
   endtask

   task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      sb.push_back(e);
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!ram_req_o && n < 20) begin
         tick();
         n++;
      end
      chk({tag, " req_wait"}, ram_req_o, 1);
   endtask

   task automatic ack_one(input string tag);
      wait_req(tag);
      ram_ack_i = 1'b1;
      tick();
      ram_ack_i = 1'b0;
   endtask

   task automatic hazard(input string name, input logic [31:0] a, input logic exp);
      read_i    = 1'b1;
      rd_addr_i = a;
      #1;
      chk(name, raw_hazard_o, exp);
      read_i    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int seen;

      // Reset values
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      chk("rst empty", empty_o, 1);
      chk("rst full", full_o, 0);
      chk("rst start", ram_write_start_o, 0);
      chk("rst req", ram_req_o, 0);
      chk("rst addr", ram_addr_o, 0);
      chk("rst data", ram_data_o, 0);
      hazard("rst hazard", 32'h0, 1'b0);

      // Single store, request two cycles after push
      expect_wr(32'h10, 32'h11);
      push(32'h10, 32'h11);
      chk("t1 empty", empty_o, 0);
      chk("t1 start", ram_write_start_o, 1);
      chk("t1 req early", ram_req_o, 0);
      tick();
      chk("t1 req", ram_req_o, 1);
      chk("t1 addr", ram_addr_o, 32'h10);
      chk("t1 data", ram_data_o, 32'h11);
      tick();
      chk("t1 req held", ram_req_o, 1);
      ram_ack_i = 1'b1;
      tick();
      ram_ack_i = 1'b0;
      chk("t1 req drop", ram_req_o, 0);
      chk("t1 empty after", empty_o, 1);
      chk("t1 start after", ram_write_start_o, 0);

      // Fill, drop a fifth store, drain in order across pointer wrap
      for (int i = 0; i < 4; i++) begin
         expect_wr(32'h100 + i, 32'hA0 + i);
         push(32'h100 + i, 32'hA0 + i);
      end
      chk("t2 full", full_o, 1);
      hazard("t2 hazard hit", 32'h102, 1'b1);
      push(32'h200, 32'hBB);
      chk("t2 full after drop", full_o, 1);
      hazard("t2 hazard dropped", 32'h200, 1'b0);
      for (int i = 0; i < 4; i++) ack_one("t2");
      chk("t2 empty", empty_o, 1);

      // Coalesce before in flight, separate entry once in flight
      push(32'h20, 32'hD1);
      push(32'h20, 32'hD2);
      expect_wr(32'h20, 32'hD2);
      chk("t3 req", ram_req_o, 1);
      chk("t3 merged data", ram_data_o, 32'hD2);
      expect_wr(32'h20, 32'hD3);
      push(32'h20, 32'hD3);
      ack_one("t3a");
      wait_req("t3b");
      chk("t3 second data", ram_data_o, 32'hD3);
      ack_one("t3b");
      chk("t3 empty", empty_o, 1);

      // Wait states hold the request stable; hazard tracks the in-flight entry
      expect_wr(32'h30, 32'h33);
      push(32'h30, 32'h33);
      wait_req("t4");
      for (int i = 0; i < 5; i++) begin
         chk("t4 req stable", ram_req_o, 1);
         chk("t4 addr stable", ram_addr_o, 32'h30);
         chk("t4 data stable", ram_data_o, 32'h33);
         tick();
      end
      hazard("t4 hazard hit", 32'h30, 1'b1);
      hazard("t4 hazard miss", 32'h31, 1'b0);
      ram_ack_i = 1'b1;
      tick();
      ram_ack_i = 1'b0;
      hazard("t4 hazard popped", 32'h30, 1'b0);

      // Push and pop together with two entries
      expect_wr(32'h40, 32'h44);
      expect_wr(32'h41, 32'h45);
      expect_wr(32'h42, 32'h46);
      push(32'h40, 32'h44);
      push(32'h41, 32'h45);
      wait_req("t5");
      ram_ack_i = 1'b1;
      push(32'h42, 32'h46);
      ram_ack_i = 1'b0;
      chk("t5 full", full_o, 0);
      chk("t5 empty", empty_o, 0);
      wait_req("t5 next");
      chk("t5 next addr", ram_addr_o, 32'h41);
      ack_one("t5b");
      ack_one("t5c");
      chk("t5 drained", empty_o, 1);

      // Push on the ack cycle while full is rejected
      for (int i = 0; i < 4; i++) begin
         expect_wr(32'h50 + i, 32'h55 + i);
         push(32'h50 + i, 32'h55 + i);
      end
      wait_req("t5f");
      chk("t5f full", full_o, 1);
      ram_ack_i = 1'b1;
      push(32'h60, 32'h66);
      ram_ack_i = 1'b0;
      chk("t5f full cleared", full_o, 0);
      for (int i = 0; i < 3; i++) ack_one("t5f");
      chk("t5f empty", empty_o, 1);

      // Reset mid-ISSUE discards everything
      push(32'h70, 32'h77);
      push(32'h71, 32'h78);
      push(32'h72, 32'h79);
      wait_req("t6");
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("t6 req", ram_req_o, 0);
      chk("t6 empty", empty_o, 1);
      chk("t6 full", full_o, 0);
      chk("t6 start", ram_write_start_o, 0);
      chk("t6 addr", ram_addr_o, 0);
      hazard("t6 hazard", 32'h71, 1'b0);
      ram_ack_i = 1'b1;
      tick();
      ram_ack_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (ram_req_o) seen++;
         tick();
      end
      chk("t6 no requests", seen, 0);
      chk("t6 empty final", empty_o, 1);

      chk("scoreboard drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
